// File: rtl/dm_port_arbiter.sv
// dm_port_arbiter
// Shares one single-port unified RAM between the instruction-fetch port and
// the load/store port. Data accesses win over fetches in IDLE because they
// belong to an older instruction. Each grant launches one RAM access that is
// held until the RAM signals ready. The response is registered and returned
// to the owner as a one-cycle rvalid pulse. A flush kills any fetch response
// that has not yet been delivered. Data accesses are never affected by flush.
module dm_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,

  // instruction-fetch requester
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [DATA_W-1:0] if_rdata_o,

  // load/store requester
  input  logic              dm_re_i,
  input  logic              dm_we_i,
  input  logic [3:0]        dm_be_n_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic              dm_gnt_o,
  output logic              dm_rvalid_o,
  output logic [DATA_W-1:0] dm_rdata_o,

  // pipeline redirect
  input  logic              flush_i,

  // RAM macro side
  output logic              ram_en_o,
  output logic [3:0]        ram_we_n_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_wdata_o,
  input  logic [DATA_W-1:0] ram_rdata_i,
  input  logic              ram_ready_i
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_BUSY = 2'd1,
    DM_BUSY = 2'd2
  } state_t;

  state_t            state_reg, state_next;

  // Access parameters captured at grant time; the RAM is driven only from
  // these so that requesters are free to change their inputs after gnt.
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [DATA_W-1:0] wdata_reg, wdata_next;
  logic [3:0]        we_n_reg, we_n_next;

  // Set while the in-flight fetch has been overtaken by a redirect.
  logic              kill_reg, kill_next;

  // Response registers, one set per requester.
  logic [DATA_W-1:0] if_rdata_reg, if_rdata_next;
  logic [DATA_W-1:0] dm_rdata_reg, dm_rdata_next;
  logic              if_rvalid_reg, if_rvalid_next;
  logic              dm_rvalid_reg, dm_rvalid_next;

  // Grant decisions before reset gating.
  logic              dm_req;
  logic              dm_gnt;
  logic              if_gnt;
  logic              busy;

  assign dm_req = dm_re_i | dm_we_i;
  assign busy   = (state_reg != IDLE);

  // State register and all captured/response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      we_n_reg      <= 4'b1111;
      kill_reg      <= 1'b0;
      if_rdata_reg  <= '0;
      dm_rdata_reg  <= '0;
      if_rvalid_reg <= 1'b0;
      dm_rvalid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      addr_reg      <= addr_next;
      wdata_reg     <= wdata_next;
      we_n_reg      <= we_n_next;
      kill_reg      <= kill_next;
      if_rdata_reg  <= if_rdata_next;
      dm_rdata_reg  <= dm_rdata_next;
      if_rvalid_reg <= if_rvalid_next;
      dm_rvalid_reg <= dm_rvalid_next;
    end
  end

  // Next-state, grant arbitration, capture and response logic.
  always_comb begin
    state_next     = state_reg;
    addr_next      = addr_reg;
    wdata_next     = wdata_reg;
    we_n_next      = we_n_reg;
    kill_next      = kill_reg;
    if_rdata_next  = if_rdata_reg;
    dm_rdata_next  = dm_rdata_reg;
    if_rvalid_next = 1'b0;
    dm_rvalid_next = 1'b0;
    dm_gnt         = 1'b0;
    if_gnt         = 1'b0;

    case (state_reg)
      IDLE: begin
        kill_next = 1'b0;
        if (dm_req) begin
          // Data port has fixed priority over fetch.
          dm_gnt     = 1'b1;
          addr_next  = dm_addr_i;
          wdata_next = dm_wdata_i;
          we_n_next  = dm_we_i ? dm_be_n_i : 4'b1111;
          state_next = DM_BUSY;
        end else if (if_req_i) begin
          // A redirect in the grant cycle still grants, but the response
          // is already dead.
          if_gnt     = 1'b1;
          addr_next  = if_addr_i;
          we_n_next  = 4'b1111;
          kill_next  = flush_i;
          state_next = IF_BUSY;
        end
      end

      IF_BUSY: begin
        if (ram_ready_i) begin
          state_next = IDLE;
          kill_next  = 1'b0;
          // A flush in the completion cycle suppresses delivery too.
          if (!kill_reg && !flush_i) begin
            if_rdata_next  = ram_rdata_i;
            if_rvalid_next = 1'b1;
          end
        end else if (flush_i) begin
          kill_next = 1'b1;
        end
      end

      DM_BUSY: begin
        if (ram_ready_i) begin
          // Stores also complete here; rvalid doubles as write acknowledge.
          state_next     = IDLE;
          dm_rdata_next  = ram_rdata_i;
          dm_rvalid_next = 1'b1;
        end
      end

      default: begin
        state_next = IDLE;
        kill_next  = 1'b0;
      end
    endcase
  end

  // Grants are combinational but held low while reset is asserted.
  assign dm_gnt_o = dm_gnt & ~rst;
  assign if_gnt_o = if_gnt & ~rst;

  assign if_rvalid_o = if_rvalid_reg;
  assign if_rdata_o  = if_rdata_reg;
  assign dm_rvalid_o = dm_rvalid_reg;
  assign dm_rdata_o  = dm_rdata_reg;

  // RAM side: enable for the whole busy period, captured values only.
  assign ram_en_o    = busy;
  assign ram_addr_o  = addr_reg;
  assign ram_wdata_o = wdata_reg;

  // Per-lane write enables: a lane is written only during a busy period and
  // only if the captured byte-enable selects it.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane_we
      assign ram_we_n_o[gi] = busy ? we_n_reg[gi] : 1'b1;
    end
  endgenerate

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Testbench for dm_port_arbiter: priority/reset vector table, directed
// multi-cycle sequences, and randomized accesses against a word-level memory
// reference model.
module tb_dm_port_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        dm_re;
  logic        dm_we;
  logic [3:0]  dm_be_n;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_gnt;
  logic        dm_rvalid;
  logic [31:0] dm_rdata;
  logic        flush;
  logic        ram_en;
  logic [3:0]  ram_we_n;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic        ram_ready;

  int checks = 0;
  int errors = 0;

  // ram_mem is the RAM macro (written from DUT outputs); ref_mem is the
  // reference view (written from the stimulus the bench issued).
  logic [31:0] ram_mem [16];
  logic [31:0] ref_mem [16];
  logic [31:0] exp_if_rdata;
  logic [31:0] exp_dm_rdata;

  dm_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt),
    .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata),
    .dm_re_i(dm_re), .dm_we_i(dm_we), .dm_be_n_i(dm_be_n),
    .dm_addr_i(dm_addr), .dm_wdata_i(dm_wdata), .dm_gnt_o(dm_gnt),
    .dm_rvalid_o(dm_rvalid), .dm_rdata_o(dm_rdata),
    .flush_i(flush),
    .ram_en_o(ram_en), .ram_we_n_o(ram_we_n), .ram_addr_o(ram_addr),
    .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata), .ram_ready_i(ram_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Byte-lane merge of a store into a word, lanes selected by active-low mask.
  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] mask_n);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++)
      if (!mask_n[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  // One isolated access started in the current (IDLE) cycle. k busy cycles,
  // ready in the last one. fl[i] is the flush value in cycle i after gnt.
  // Returns in the rvalid cycle with all requests dropped.
  task automatic access(input bit is_dm, input bit wr, input logic [3:0] be_n,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input int k, input logic [7:0] fl, input string tag);
    logic        killed;
    logic [3:0]  exp_we_n;
    logic [31:0] old_word;
    int          idx;
    idx      = int'(addr[5:2]);
    old_word = ref_mem[idx];
    exp_we_n = (is_dm && wr) ? be_n : 4'b1111;
    if (is_dm) begin
      dm_re = !wr; dm_we = wr; dm_be_n = be_n; dm_addr = addr; dm_wdata = wdata;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    flush = fl[0]; ram_ready = 1'b0;
    #1;
    chk({tag, ".dm_gnt"}, 32'(dm_gnt), 32'(is_dm));
    chk({tag, ".if_gnt"}, 32'(if_gnt), 32'(!is_dm));
    killed = !is_dm && fl[0];
    for (int i = 1; i <= k; i++) begin
      cyc();
      dm_re = 1'b0; dm_we = 1'b0; if_req = 1'b0;
      dm_be_n = 4'($urandom); dm_addr = $urandom; dm_wdata = $urandom; if_addr = $urandom;
      flush = fl[i];
      if (!is_dm && fl[i]) killed = 1'b1;
      ram_ready = (i == k);
      ram_rdata = (i == k) ? ram_mem[ram_addr[5:2]] : $urandom;
      #1;
      chk({tag, ".en"}, 32'(ram_en), 32'd1);
      chk({tag, ".addr"}, ram_addr, addr);
      chk({tag, ".we_n"}, 32'(ram_we_n), 32'(exp_we_n));
      if (is_dm && wr) chk({tag, ".wdata"}, ram_wdata, wdata);
      chk({tag, ".busy_gnt"}, 32'({dm_gnt, if_gnt}), 32'd0);
      chk({tag, ".busy_rvalid"}, 32'({dm_rvalid, if_rvalid}), 32'd0);
      if (i == k && ram_en) begin
        for (int b = 0; b < 4; b++)
          if (!ram_we_n[b]) ram_mem[ram_addr[5:2]][8*b +: 8] = ram_wdata[8*b +: 8];
      end
    end
    if (is_dm && wr) ref_mem[idx] = merge(ref_mem[idx], wdata, be_n);
    cyc();
    flush = 1'b0; ram_ready = 1'b0;
    #1;
    if (is_dm) exp_dm_rdata = old_word;
    else if (!killed) exp_if_rdata = old_word;
    chk({tag, ".dm_rvalid"}, 32'(dm_rvalid), 32'(is_dm));
    chk({tag, ".if_rvalid"}, 32'(if_rvalid), 32'(!is_dm && !killed));
    chk({tag, ".dm_rdata"}, dm_rdata, exp_dm_rdata);
    chk({tag, ".if_rdata"}, if_rdata, exp_if_rdata);
    $display("txn %0s dm=%0d wr=%0d be_n=%b addr=%h k=%0d flush=%b killed=%0d",
             tag, is_dm, wr, be_n, addr, k, fl, killed);
  endtask

  typedef struct {
    logic        dm_re;
    logic        dm_we;
    logic [3:0]  be_n;
    logic        if_req;
    logic        flush;
    logic        exp_dm_gnt;
    logic        exp_if_gnt;
    logic        exp_en;
    logic [3:0]  exp_we_n;
    logic [31:0] exp_addr;
  } vec_t;

  vec_t vt [9];

  initial begin
    // dm_addr = 0x1000+4i, if_addr = 0x2000+4i for vector i
    vt[0] = '{1'b0, 1'b0, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'hF, 32'h0};
    vt[1] = '{1'b0, 1'b0, 4'hF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'hF, 32'h2004};
    vt[2] = '{1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'hF, 32'h1008};
    vt[3] = '{1'b0, 1'b1, 4'hC, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'hC, 32'h100C};
    vt[4] = '{1'b0, 1'b1, 4'hC, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'hC, 32'h1010};
    vt[5] = '{1'b1, 1'b0, 4'h3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'hF, 32'h1014};
    vt[6] = '{1'b0, 1'b1, 4'hF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'hF, 32'h1018};
    vt[7] = '{1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'hF, 32'h201C};
    vt[8] = '{1'b0, 1'b1, 4'h5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'h5, 32'h1020};

    for (int i = 0; i < 16; i++) begin
      ram_mem[i] = $urandom;
      ref_mem[i] = ram_mem[i];
    end
    ram_mem[0] = 32'hDEADBEEF;
    ref_mem[0] = 32'hDEADBEEF;

    rst = 1'b1; if_req = 1'b0; if_addr = '0; dm_re = 1'b0; dm_we = 1'b0;
    dm_be_n = 4'hF; dm_addr = '0; dm_wdata = '0; flush = 1'b0;
    ram_rdata = '0; ram_ready = 1'b0;
    repeat (3) cyc();
    rst = 1'b0;
    cyc();
    chk("reset.en", 32'(ram_en), 32'd0);
    chk("reset.we_n", 32'(ram_we_n), 32'hF);
    chk("reset.addr", ram_addr, 32'd0);
    chk("reset.wdata", ram_wdata, 32'd0);
    chk("reset.rdata", if_rdata | dm_rdata, 32'd0);
    chk("reset.pulses", 32'({if_gnt, dm_gnt, if_rvalid, dm_rvalid}), 32'd0);

    // Priority table; each grant is cut short by a reset in the busy cycle,
    // which also collides with ram_ready so the response must be lost.
    for (int i = 0; i < 9; i++) begin
      dm_re = vt[i].dm_re; dm_we = vt[i].dm_we; dm_be_n = vt[i].be_n;
      if_req = vt[i].if_req; flush = vt[i].flush;
      dm_addr = 32'h1000 + 32'(4 * i); if_addr = 32'h2000 + 32'(4 * i);
      dm_wdata = 32'hC0DE0000 + 32'(i);
      #1;
      chk($sformatf("vec%0d.dm_gnt", i), 32'(dm_gnt), 32'(vt[i].exp_dm_gnt));
      chk($sformatf("vec%0d.if_gnt", i), 32'(if_gnt), 32'(vt[i].exp_if_gnt));
      cyc();
      dm_re = 1'b0; dm_we = 1'b0; if_req = 1'b0; flush = 1'b0;
      rst = 1'b1; ram_ready = 1'b1; ram_rdata = 32'hA5A50000 + 32'(i);
      #1;
      chk($sformatf("vec%0d.en", i), 32'(ram_en), 32'(vt[i].exp_en));
      chk($sformatf("vec%0d.we_n", i), 32'(ram_we_n), 32'(vt[i].exp_we_n));
      chk($sformatf("vec%0d.addr", i), ram_addr, vt[i].exp_addr);
      cyc();
      rst = 1'b0; ram_ready = 1'b0;
      #1;
      chk($sformatf("vec%0d.rst_en", i), 32'(ram_en), 32'd0);
      chk($sformatf("vec%0d.rst_we_n", i), 32'(ram_we_n), 32'hF);
      chk($sformatf("vec%0d.rst_rvalid", i), 32'({dm_rvalid, if_rvalid}), 32'd0);
      chk($sformatf("vec%0d.rst_rdata", i), dm_rdata | if_rdata, 32'd0);
    end
    exp_if_rdata = '0;
    exp_dm_rdata = '0;

    // Directed sequences.
    access(1'b1, 1'b0, 4'hF, 32'h100, 32'h0, 1, 8'h00, "single_load");
    access(1'b0, 1'b0, 4'hF, 32'h104, 32'h0, 4, 8'h00, "fetch_wait3");
    access(1'b0, 1'b0, 4'hF, 32'h108, 32'h0, 3, 8'b0000_0010, "fetch_flush_busy");
    access(1'b0, 1'b0, 4'hF, 32'h108, 32'h0, 1, 8'h00, "fetch_after_flush");
    access(1'b0, 1'b0, 4'hF, 32'h110, 32'h0, 2, 8'b0000_0001, "fetch_flush_gnt");
    access(1'b0, 1'b0, 4'hF, 32'h114, 32'h0, 2, 8'b0000_0100, "fetch_flush_ready");
    access(1'b1, 1'b1, 4'hF, 32'h118, 32'hFFFFFFFF, 2, 8'h00, "null_store");
    access(1'b1, 1'b0, 4'hF, 32'h118, 32'h0, 1, 8'h00, "load_after_null");
    access(1'b1, 1'b0, 4'hF, 32'h11C, 32'h0, 2, 8'b0000_0111, "load_flush_ignored");

    // Conflict: store and fetch raised together; fetch is granted in the
    // cycle of the store's rvalid.
    dm_we = 1'b1; dm_be_n = 4'b1100; dm_addr = 32'h108; dm_wdata = 32'h12345678;
    if_req = 1'b1; if_addr = 32'h10C; flush = 1'b0;
    #1;
    chk("conflict.dm_gnt", 32'(dm_gnt), 32'd1);
    chk("conflict.if_gnt0", 32'(if_gnt), 32'd0);
    cyc();
    dm_we = 1'b0; ram_ready = 1'b1; ram_rdata = ram_mem[ram_addr[5:2]];
    #1;
    chk("conflict.we_n", 32'(ram_we_n), 32'hC);
    chk("conflict.addr", ram_addr, 32'h108);
    chk("conflict.wdata", ram_wdata, 32'h12345678);
    chk("conflict.busy_if_gnt", 32'(if_gnt), 32'd0);
    exp_dm_rdata = ref_mem[2];
    for (int b = 0; b < 4; b++)
      if (!ram_we_n[b]) ram_mem[ram_addr[5:2]][8*b +: 8] = ram_wdata[8*b +: 8];
    ref_mem[2] = merge(ref_mem[2], 32'h12345678, 4'b1100);
    cyc();
    ram_ready = 1'b0;
    #1;
    chk("conflict.dm_rvalid", 32'(dm_rvalid), 32'd1);
    chk("conflict.if_gnt1", 32'(if_gnt), 32'd1);
    cyc();
    if_req = 1'b0; ram_ready = 1'b1; ram_rdata = ram_mem[ram_addr[5:2]];
    #1;
    chk("conflict.if_addr", ram_addr, 32'h10C);
    chk("conflict.if_we_n", 32'(ram_we_n), 32'hF);
    cyc();
    ram_ready = 1'b0;
    #1;
    exp_if_rdata = ref_mem[3];
    chk("conflict.if_rvalid", 32'(if_rvalid), 32'd1);
    chk("conflict.if_rdata", if_rdata, exp_if_rdata);
    chk("conflict.dm_rdata", dm_rdata, exp_dm_rdata);
    $display("txn conflict store@108 then fetch@10C");
    access(1'b1, 1'b0, 4'hF, 32'h108, 32'h0, 1, 8'h00, "load_merged");

    // Randomized accesses against the memory reference model.
    for (int n = 0; n < 40; n++) begin
      bit          r_dm, r_wr;
      logic [3:0]  r_be;
      logic [7:0]  r_fl;
      logic [31:0] r_addr;
      r_dm   = 1'($urandom);
      r_wr   = 1'($urandom);
      r_be   = 4'($urandom);
      r_addr = 32'h100 + 32'(4 * $urandom_range(0, 15));
      r_fl   = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
      access(r_dm, r_wr, r_be, r_addr, $urandom, int'($urandom_range(1, 4)), r_fl,
             $sformatf("rand%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dm_port_arbiter.md
# dm_port_arbiter

Shares the single-port unified RAM between the instruction-fetch requester and the data-memory requester (the load/store stage), and sequences each access over a variable-latency RAM handshake. Sits between the IF stage / memory-access stage and the RAM macro. Returns read data and completion pulses to the owning requester. Cancels in-flight fetch responses on a pipeline flush.

## Interface
Parameters:
- `ADDR_W`, 32, address width.
- `DATA_W`, 32, data width. Fixed 4 byte lanes; only 32 is supported.

Ports:
- `clk`  in  1  clock. Single clock domain.
- `rst`  in  1  reset, synchronous, active-high.
- `if_req_i`  in  1  fetch request. Held high until granted.
- `if_addr_i`  in  ADDR_W  fetch address. Word-aligned.
- `if_gnt_o`  out  1  fetch request accepted (pulse).
- `if_rvalid_o`  out  1  fetch data valid (pulse).
- `if_rdata_o`  out  DATA_W  fetch data.
- `dm_re_i`  in  1  load request. Held until granted.
- `dm_we_i`  in  1  store request. Held until granted. Never asserted together with `dm_re_i`.
- `dm_be_n_i`  in  4  active-low byte enables for stores.
- `dm_addr_i`  in  ADDR_W  data address.
- `dm_wdata_i`  in  DATA_W  store data.
- `dm_gnt_o`  out  1  data request accepted (pulse).
- `dm_rvalid_o`  out  1  data access complete (pulse). For loads, data is valid. For stores, acts as the write acknowledge.
- `dm_rdata_o`  out  DATA_W  load data: the full word. Lane extraction is downstream.
- `flush_i`  in  1  pipeline redirect. Kills any fetch response not yet delivered.
- `ram_en_o`  out  1  RAM access active.
- `ram_we_n_o`  out  4  active-low byte write enables.
- `ram_addr_o`  out  ADDR_W  RAM address.
- `ram_wdata_o`  out  DATA_W  RAM write data.
- `ram_rdata_i`  in  DATA_W  RAM read data. Valid when `ram_ready_i` is high.
- `ram_ready_i`  in  1  RAM completes the current access this cycle.

## Operation
- States: `IDLE`, `IF_BUSY`, `DM_BUSY`.
- **IDLE**
  - `dm_re_i|dm_we_i` → `dm_gnt_o=1` (combinational), latch the data request, next state `DM_BUSY`.
  - Otherwise, `if_req_i` → `if_gnt_o=1`, latch the fetch request, next state `IF_BUSY`.
  - Fixed priority: data beats fetch, because the data access belongs to an older instruction.
- **In IF_BUSY / DM_BUSY**
  - `ram_en_o=1`, driven from latched registers only.
  - `ram_we_n_o` = latched `dm_be_n_i` for stores, `4'b1111` for loads and fetches.
  - On `ram_ready_i`:
    - register `ram_rdata_i` into the owner's rdata register;
    - pulse the owner's rvalid in the next cycle;
    - return to `IDLE`.
- Gnt is never asserted outside `IDLE`. Requesters keep req/addr/data stable until they see gnt.
- Store with `dm_be_n_i=4'b1111`: runs a full RAM cycle with no lanes written, then `dm_rvalid_o` pulses normally.
- **Flush**
  - `flush_i` in `IF_BUSY`, or in the same cycle as `if_gnt_o`: sets `kill`. The RAM access completes, but `if_rvalid_o` is suppressed and `if_rdata_o` is not updated. `kill` clears on return to `IDLE`.
  - `flush_i` while `if_rvalid_o` is about to pulse (the cycle of `ram_ready_i`): the pulse is suppressed.
  - `flush_i` never affects data accesses.
- `flush_i` together with `if_req_i` in `IDLE`: the request is still granted and `kill` is set in the same cycle. The requester issues its redirected fetch afterwards.

## Timing
- Reset values:
  - state `IDLE`;
  - `ram_en_o=0`, `ram_we_n_o=4'b1111`;
  - `ram_addr_o`, `ram_wdata_o`, `if_rdata_o`, `dm_rdata_o` = 0;
  - all gnt/rvalid = 0;
  - `kill=0`.
- Reset mid-access: the state machine returns to `IDLE` at the next edge and `ram_en_o` drops. The pending response is lost and no rvalid is produced.
- Latency:
  - gnt in cycle T;
  - `ram_en_o` high from T+1;
  - if `ram_ready_i` arrives in cycle T+k (k≥1), rvalid pulses in T+k+1.
  - Minimum gnt→rvalid is 2 cycles.
- The next gnt can occur in the same cycle as the previous rvalid, because the state is already `IDLE`. Peak throughput is one access per 2 cycles.
- `ram_addr_o`, `ram_wdata_o` and `ram_we_n_o` are stable for the whole busy period.
- rvalid is exactly one cycle wide. rdata holds its value until the next completion for that requester.

## Test plan
- Single load: `dm_re_i` at `0x100`, RAM returns `0xDEADBEEF` with `ram_ready_i` in the first busy cycle → `dm_gnt_o` in T, `ram_en_o` in T+1, `dm_rvalid_o=1` with `dm_rdata_o=0xDEADBEEF` in T+2.
- Conflict: `if_req_i` and `dm_we_i` (`be_n=4'b1100`, data `0x1234_5678`) raised together → data granted first with `ram_we_n_o=4'b1100`. Fetch is granted in the cycle of `dm_rvalid_o`.
- Wait states: fetch with `ram_ready_i` delayed 3 cycles → `ram_en_o` high for 4 cycles with a constant address. `if_rvalid_o` arrives 5 cycles after gnt.
- Flush: fetch granted, `flush_i` pulsed in the first busy cycle, `ram_ready_i` 2 cycles later → no `if_rvalid_o` and `if_rdata_o` unchanged. The next fetch completes normally.
- Reset mid-access: `rst` asserted while in `DM_BUSY` → next cycle `ram_en_o=0`, `ram_we_n_o=4'b1111`, no `dm_rvalid_o`. A new load after reset completes.
- Null store: `dm_we_i` with `be_n=4'b1111` → `ram_we_n_o=4'b1111` during access, and `dm_rvalid_o` still pulses.
